// File: rtl/ifetch_stage_pkg.sv
// Shared definitions for the instruction-fetch stage and its skid buffer.
`timescale 1ns/1ps
package ifetch_stage_pkg;

  localparam logic [31:0]  NOP_INSTR        = 32'h0000_0013;
  localparam logic [31:0]  DEFAULT_RESET_PC = 32'h0000_0000;
  localparam int unsigned  SKID_ENTRIES     = 2;

  typedef enum logic [1:0] {
    IF_BOOT   = 2'd0,
    IF_RUN    = 2'd1,
    IF_HALTED = 2'd2
  } if_state_e;

  function automatic logic is_word_aligned(input logic [31:0] addr);
    return (addr[1:0] == 2'b00);
  endfunction

endpackage

// File: rtl/ifetch_stage_skid_buf.sv
// Two-entry FIFO of {pc, instr} that absorbs fetch responses while decode stalls.
`timescale 1ns/1ps
module fetch_skid_buf
  import ifetch_stage_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        push,
  input  logic        pop,
  input  logic        flush,
  input  logic [31:0] push_pc,
  input  logic [31:0] push_instr,
  output logic [1:0]  count,
  output logic [31:0] head_pc,
  output logic [31:0] head_instr,
  output logic        empty,
  output logic        full
);

  logic [31:0] pc_mem    [SKID_ENTRIES];
  logic [31:0] instr_mem [SKID_ENTRIES];
  logic        wr_ptr;
  logic        rd_ptr;
  logic [1:0]  count_q;

  // Entry storage plus read/write pointer and occupancy bookkeeping; flush wins over push/pop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr  <= 1'b0;
      rd_ptr  <= 1'b0;
      count_q <= '0;
      for (int unsigned i = 0; i < SKID_ENTRIES; i++) begin
        pc_mem[i]    <= '0;
        instr_mem[i] <= '0;
      end
    end else if (flush) begin
      wr_ptr  <= 1'b0;
      rd_ptr  <= 1'b0;
      count_q <= '0;
    end else begin
      if (push) begin
        pc_mem[wr_ptr]    <= push_pc;
        instr_mem[wr_ptr] <= push_instr;
        wr_ptr            <= ~wr_ptr;
      end
      if (pop) begin
        rd_ptr <= ~rd_ptr;
      end
      case ({push, pop})
        2'b10:   count_q <= count_q + 2'd1;
        2'b01:   count_q <= count_q - 2'd1;
        default: count_q <= count_q;
      endcase
    end
  end

  assign count      = count_q;
  assign head_pc    = pc_mem[rd_ptr];
  assign head_instr = instr_mem[rd_ptr];
  assign empty      = (count_q == 2'd0);
  assign full       = (count_q == 2'(SKID_ENTRIES));

  a_no_push_when_full: assert property (@(posedge clk) disable iff (!rst_n) !(push && full));
  a_no_pop_when_empty: assert property (@(posedge clk) disable iff (!rst_n) !(pop && empty));

endmodule

// File: rtl/ifetch_stage.sv
// Instruction-fetch stage: owns the fetch PC, issues 1-cycle-latency memory reads,
// buffers responses in a skid FIFO under decode back-pressure and drives IF/ID.
`timescale 1ns/1ps
module ifetch_stage
  import ifetch_stage_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = DEFAULT_RESET_PC,
  parameter int unsigned SKID_DEPTH = SKID_ENTRIES
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall_in,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  input  logic        halt_req,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instr_out_if,
  output logic [31:0] pc_out_if,
  output logic        valid_out_if,
  output logic        halt_out_if
);

  if_state_e   state_q;
  logic [31:0] pc_fetch;
  logic [31:0] pc_inflight;
  logic        inflight;

  logic        halt_take;
  logic        redirect_take;
  logic        issue;
  logic        resp_valid;
  logic [31:0] occupancy;

  logic        skid_push;
  logic        skid_pop;
  logic        skid_flush;
  logic [1:0]  skid_count;
  logic [31:0] skid_head_pc;
  logic [31:0] skid_head_instr;
  logic        skid_empty;
  logic        skid_full;

  // Per-cycle decisions: halt beats redirect, a redirect or halt kills the response
  // arriving this cycle and suppresses issue, and issue is capped so that every
  // outstanding response is guaranteed a skid slot.
  always_comb begin
    halt_take     = halt_req && (state_q != IF_HALTED);
    redirect_take = redirect_valid && !halt_take && (state_q != IF_HALTED);
    occupancy     = 32'(skid_count) + 32'(inflight);
    issue         = (state_q == IF_RUN) && !halt_req && !redirect_valid &&
                    (occupancy < SKID_DEPTH);
    resp_valid    = inflight && (state_q == IF_RUN) && !halt_req && !redirect_valid;
    skid_flush    = redirect_take || halt_take || (state_q == IF_HALTED);
    skid_pop      = !stall_in && !skid_empty && !skid_flush;
    skid_push     = resp_valid && (stall_in || !skid_empty);
  end

  assign imem_req  = issue;
  assign imem_addr = pc_fetch;

  fetch_skid_buf u_skid (
    .clk        (clk),
    .rst_n      (rst),
    .push       (skid_push),
    .pop        (skid_pop),
    .flush      (skid_flush),
    .push_pc    (pc_inflight),
    .push_instr (imem_rdata),
    .count      (skid_count),
    .head_pc    (skid_head_pc),
    .head_instr (skid_head_instr),
    .empty      (skid_empty),
    .full       (skid_full)
  );

  // FSM, fetch-PC and in-flight tracking, and the IF/ID register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= IF_BOOT;
      pc_fetch     <= RESET_PC;
      pc_inflight  <= '0;
      inflight     <= 1'b0;
      instr_out_if <= NOP_INSTR;
      pc_out_if    <= '0;
      valid_out_if <= 1'b0;
      halt_out_if  <= 1'b0;
    end else begin
      // The in-flight flag only survives for requests issued this cycle, which
      // drops any response belonging to a redirect or halt cycle.
      inflight <= issue;
      if (issue) begin
        pc_fetch    <= pc_fetch + 32'd4;
        pc_inflight <= pc_fetch;
      end

      if (halt_take) begin
        state_q      <= IF_HALTED;
        halt_out_if  <= 1'b1;
        instr_out_if <= NOP_INSTR;
        valid_out_if <= 1'b0;
      end else if (redirect_take) begin
        instr_out_if <= NOP_INSTR;
        valid_out_if <= 1'b0;
        if (is_word_aligned(redirect_pc)) begin
          pc_fetch <= redirect_pc;
          state_q  <= IF_RUN;
        end else begin
          pc_out_if   <= redirect_pc;
          halt_out_if <= 1'b1;
          state_q     <= IF_HALTED;
        end
      end else if (state_q == IF_BOOT) begin
        state_q <= IF_RUN;
      end else if ((state_q == IF_RUN) && !stall_in) begin
        // Skid entries are older than the response arriving now, so they go first.
        if (!skid_empty) begin
          pc_out_if    <= skid_head_pc;
          instr_out_if <= skid_head_instr;
          valid_out_if <= 1'b1;
        end else if (resp_valid) begin
          pc_out_if    <= pc_inflight;
          instr_out_if <= imem_rdata;
          valid_out_if <= 1'b1;
        end else begin
          instr_out_if <= NOP_INSTR;
          valid_out_if <= 1'b0;
        end
      end
    end
  end

  a_no_resp_into_full_skid: assert property (@(posedge clk) disable iff (!rst)
    !(resp_valid && skid_full));

endmodule
